// File: rtl/vc_allocator_pkg.sv
// rtl/vc_allocator_pkg.sv - shared router parameters and port encoding for the VC allocator
package vc_allocator_pkg;

  localparam int PORT_NUM  = 5;
  localparam int VC_NUM    = 2;
  localparam int VC_SIZE   = $clog2(VC_NUM);
  localparam int FLAT_NUM  = PORT_NUM * VC_NUM;
  localparam int FLAT_SIZE = $clog2(FLAT_NUM);

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    WEST  = 3'd3,
    EAST  = 3'd4
  } port_t;

  function automatic logic port_valid(input port_t p);
    return p inside {LOCAL, NORTH, SOUTH, WEST, EAST};
  endfunction

endpackage

// File: rtl/vc_allocator_arbiter.sv
// rtl/vc_allocator_arbiter.sv - combinational round-robin arbiter; caller owns the pointer
module vc_allocator_arbiter #(
  parameter int AGENTS_NUM = 2,
  parameter int PTR_W      = (AGENTS_NUM > 1) ? $clog2(AGENTS_NUM) : 1
) (
  input  logic [AGENTS_NUM-1:0] requests_i,
  input  logic [PTR_W-1:0]      ptr_i,
  output logic [AGENTS_NUM-1:0] grants_o
);

  logic [AGENTS_NUM-1:0] high_mask;
  logic [AGENTS_NUM-1:0] high_req;
  logic [AGENTS_NUM-1:0] pick;

  // Prefer requesters at or above the pointer, else wrap to the lowest one.
  always_comb begin
    high_mask = ~((AGENTS_NUM'(1) << ptr_i) - AGENTS_NUM'(1));
    high_req  = requests_i & high_mask;
    pick      = (|high_req) ? high_req : requests_i;
    grants_o  = pick & (~pick + AGENTS_NUM'(1));
  end

endmodule

// File: rtl/vc_allocator.sv
// rtl/vc_allocator.sv - separable input-first virtual-channel allocator
module vc_allocator
  import vc_allocator_pkg::*;
(
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic  [PORT_NUM-1:0][VC_NUM-1:0]             request_i,
  input  port_t [PORT_NUM-1:0][VC_NUM-1:0]             out_port_i,
  input  logic  [PORT_NUM-1:0][VC_NUM-1:0]             release_i,
  output logic  [PORT_NUM-1:0][VC_NUM-1:0]             vc_valid_o,
  output logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] vc_new_o
);

  logic [PORT_NUM-1:0][VC_NUM-1:0]                avail, avail_nxt;
  logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0]   in_ptr, in_ptr_nxt;
  logic [PORT_NUM-1:0][VC_NUM-1:0][FLAT_SIZE-1:0] out_ptr, out_ptr_nxt;
  logic [PORT_NUM-1:0][VC_NUM-1:0][VC_NUM-1:0]    s1_req, s1_gnt;
  logic [PORT_NUM-1:0][VC_NUM-1:0][FLAT_NUM-1:0]  s2_req, s2_gnt;
  logic [PORT_NUM-1:0][VC_NUM-1:0]                win;
  logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0]   win_vc;

  // Stage 1: a VC just granted is masked so it cannot win a second VC.
  always_comb begin
    s1_req = '0;
    for (int ip = 0; ip < PORT_NUM; ip++) begin
      for (int iv = 0; iv < VC_NUM; iv++) begin
        if (request_i[ip][iv] && !vc_valid_o[ip][iv] && port_valid(out_port_i[ip][iv]))
          s1_req[ip][iv] = avail[out_port_i[ip][iv]];
      end
    end
  end

  for (genvar ip = 0; ip < PORT_NUM; ip++) begin : g_in_port
    for (genvar iv = 0; iv < VC_NUM; iv++) begin : g_in_vc
      vc_allocator_arbiter #(.AGENTS_NUM(VC_NUM)) u_in_arb (
        .requests_i (s1_req[ip][iv]),
        .ptr_i      (in_ptr[ip][iv]),
        .grants_o   (s1_gnt[ip][iv])
      );
    end
  end

  always_comb begin
    s2_req = '0;
    for (int op = 0; op < PORT_NUM; op++) begin
      for (int ov = 0; ov < VC_NUM; ov++) begin
        for (int ip = 0; ip < PORT_NUM; ip++) begin
          for (int iv = 0; iv < VC_NUM; iv++) begin
            if (s1_gnt[ip][iv][ov] && out_port_i[ip][iv] == port_t'(op))
              s2_req[op][ov][ip*VC_NUM+iv] = 1'b1;
          end
        end
      end
    end
  end

  for (genvar op = 0; op < PORT_NUM; op++) begin : g_out_port
    for (genvar ov = 0; ov < VC_NUM; ov++) begin : g_out_vc
      vc_allocator_arbiter #(.AGENTS_NUM(FLAT_NUM)) u_out_arb (
        .requests_i (s2_req[op][ov]),
        .ptr_i      (out_ptr[op][ov]),
        .grants_o   (s2_gnt[op][ov])
      );
    end
  end

  // Releases apply before grants so a grant on a VC always leaves it owned.
  always_comb begin
    win         = '0;
    win_vc      = '0;
    avail_nxt   = avail | release_i;
    in_ptr_nxt  = in_ptr;
    out_ptr_nxt = out_ptr;
    for (int op = 0; op < PORT_NUM; op++) begin
      for (int ov = 0; ov < VC_NUM; ov++) begin
        for (int f = 0; f < FLAT_NUM; f++) begin
          if (s2_gnt[op][ov][f]) begin
            avail_nxt[op][ov]                     = 1'b0;
            out_ptr_nxt[op][ov]                   = (f == FLAT_NUM-1) ? '0 : FLAT_SIZE'(f + 1);
            win[f / VC_NUM][f % VC_NUM]           = 1'b1;
            win_vc[f / VC_NUM][f % VC_NUM]        = VC_SIZE'(ov);
            in_ptr_nxt[f / VC_NUM][f % VC_NUM]    = (ov == VC_NUM-1) ? '0 : VC_SIZE'(ov + 1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vc_valid_o <= '0;
      vc_new_o   <= '0;
      avail      <= '1;
      in_ptr     <= '0;
      out_ptr    <= '0;
    end else begin
      vc_valid_o <= win;
      avail      <= avail_nxt;
      in_ptr     <= in_ptr_nxt;
      out_ptr    <= out_ptr_nxt;
      for (int ip = 0; ip < PORT_NUM; ip++) begin
        for (int iv = 0; iv < VC_NUM; iv++) begin
          if (win[ip][iv])
            vc_new_o[ip][iv] <= win_vc[ip][iv];
        end
      end
    end
  end

endmodule
